// File: rtl/beep_generator.sv
// rtl/beep_generator.sv - piezo beep generator: timed square-wave tones with stop and drop reporting
// Optional BEEP_QUEUE_EN: one pending tone, played after GAP_MS of silence.
module beep_generator #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int GAP_MS      = 20
) (
    input  logic        sys_clock,
    input  logic        reset_n,
    input  logic        tone_req,
    input  logic [19:0] tone_half_period,
    input  logic [9:0]  tone_duration_ms,
    input  logic        stop_req,
    output logic        req_ready,
    output logic        req_dropped,
    output logic        tone_done,
    output logic        buzzer_out
);

`ifdef BEEP_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int GAP_CYC    = GAP_MS * CYC_PER_MS;
    localparam int PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int HP_W       = $clog2(20'hF_FFFF);
    localparam int MS_W       = $clog2(1023);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_MS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [19:0]      hp_r;
    logic [9:0]       dur_r;
    logic [HP_W-1:0]  hp_cnt;
    logic [PRE_W-1:0] pre_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pend_valid;
    logic [19:0]      pend_hp;
    logic [9:0]       pend_dur;
    logic             ready_en;

    logic             accept;
    logic             play_last;
    logic             start_now;
    logic [19:0]      start_hp;
    logic [9:0]       start_dur;

    // ready_en keeps req_ready low until the first edge after reset release
    assign req_ready = ready_en && ((state == ST_IDLE) || (QUEUE_EN && !pend_valid));
    assign accept    = tone_req && req_ready && !stop_req;
    assign play_last = (state == ST_PLAY) && (pre_cnt == PRE_LAST)
                       && (ms_cnt == MS_W'(dur_r - 10'd1));

    always_comb begin
        start_now = 1'b0;
        start_hp  = tone_half_period;
        start_dur = tone_duration_ms;
        if (state == ST_IDLE && accept) begin
            start_now = 1'b1;
        end else if (state == ST_GAP && gap_cnt == GAP_LAST) begin
            start_now = 1'b1;
            start_hp  = pend_hp;
            start_dur = pend_dur;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hp_r        <= '0;
            dur_r       <= '0;
            hp_cnt      <= '0;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
            gap_cnt     <= '0;
            pend_valid  <= 1'b0;
            pend_hp     <= '0;
            pend_dur    <= '0;
            ready_en    <= 1'b0;
            req_dropped <= 1'b0;
            tone_done   <= 1'b0;
            buzzer_out  <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            tone_done   <= 1'b0;
            req_dropped <= tone_req && (!req_ready || stop_req);
            if (stop_req) begin
                state      <= ST_IDLE;
                buzzer_out <= 1'b0;
                pend_valid <= 1'b0;
            end else if (start_now) begin
                hp_r    <= start_hp;
                dur_r   <= start_dur;
                hp_cnt  <= '0;
                pre_cnt <= '0;
                ms_cnt  <= '0;
                if (state == ST_GAP) begin
                    pend_valid <= 1'b0;
                end
                // a zero-length tone completes immediately without sound
                if (start_dur == 10'd0) begin
                    state      <= ST_IDLE;
                    buzzer_out <= 1'b0;
                    tone_done  <= 1'b1;
                end else begin
                    state      <= ST_PLAY;
                    buzzer_out <= (start_hp != 20'd0);
                end
            end else if (state == ST_PLAY) begin
                if (QUEUE_EN && accept) begin
                    pend_valid <= 1'b1;
                    pend_hp    <= tone_half_period;
                    pend_dur   <= tone_duration_ms;
                end
                if (play_last) begin
                    buzzer_out <= 1'b0;
                    tone_done  <= 1'b1;
                    gap_cnt    <= '0;
                    state      <= (pend_valid || (QUEUE_EN && accept)) ? ST_GAP : ST_IDLE;
                end else begin
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt <= '0;
                        ms_cnt  <= ms_cnt + 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                    if (hp_r != 20'd0) begin
                        if (hp_cnt == HP_W'(hp_r - 20'd1)) begin
                            hp_cnt     <= '0;
                            buzzer_out <= !buzzer_out;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beep_generator.sv
// tb/tb_beep_generator.sv - self-checking bench for beep_generator (100 cycles/ms, GAP_MS=2)
module tb_beep_generator;

    localparam int CLK_HZ  = 100_000;
    localparam int CPM     = 100;
    localparam int GAP_CYC = 200;
`ifdef BEEP_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic        sys_clock = 1'b0;
    logic        reset_n;
    logic        tone_req;
    logic [19:0] tone_half_period;
    logic [9:0]  tone_duration_ms;
    logic        stop_req;
    logic        req_ready;
    logic        req_dropped;
    logic        tone_done;
    logic        buzzer_out;

    int n_pass  = 0;
    int n_total = 0;

    beep_generator #(.CLK_FREQ_HZ(CLK_HZ), .GAP_MS(2)) dut (
        .sys_clock        (sys_clock),
        .reset_n          (reset_n),
        .tone_req         (tone_req),
        .tone_half_period (tone_half_period),
        .tone_duration_ms (tone_duration_ms),
        .stop_req         (stop_req),
        .req_ready        (req_ready),
        .req_dropped      (req_dropped),
        .tone_done        (tone_done),
        .buzzer_out       (buzzer_out)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [19:0] hp;
        logic [9:0]  dur;
        int          done_rel;
        int          high;
        int          changes;
    } vec_t;

    typedef struct {
        int st;
        int en;
        int h;
    } tone_t;

    vec_t  vecs [7];
    tone_t tones [$];
    logic  rec_bz   [0:699];
    logic  rec_td   [0:699];
    logic  rec_rdy  [0:699];
    logic  rec_drop [0:699];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic req, input logic [19:0] hp, input logic [9:0] dur, input logic stp);
        tone_req         = req;
        tone_half_period = hp;
        tone_duration_ms = dur;
        stop_req         = stp;
    endtask

    task automatic do_reset();
        drive(1'b0, 20'd0, 10'd0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge sys_clock);
        reset_n = 1'b1;
    endtask

    // Reference model: each accepted tone is an absolute [st, en) cycle window
    function automatic bit m_idle(input int n);
        foreach (tones[i]) if (tones[i].en > n) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_pend(input int n);
        foreach (tones[i]) if (tones[i].st > n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input int n);
        if (n < 1) return 1'b0;
        return QUEUE ? !m_pend(n) : m_idle(n);
    endfunction

    function automatic bit m_buzz(input int n);
        foreach (tones[i])
            if (tones[i].st <= n && n < tones[i].en && tones[i].h != 0
                && ((n - tones[i].st) / tones[i].h) % 2 == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_done(input int n);
        foreach (tones[i]) if (tones[i].en == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count_ones(input int kind, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            if (kind == 0 && rec_bz[i]) c++;
            if (kind == 1 && rec_td[i]) c++;
        end
        return c;
    endfunction

    initial begin
        int   done_rel, done_cnt, high, changes, last, st;
        logic prev;
        bit   r, s, rdy, exp_drop;
        logic [19:0] h;
        logic [9:0]  d;

        vecs[0] = '{20'd10,  10'd3, 300, 150, 30};
        vecs[1] = '{20'd0,   10'd1, 100, 0,   0};
        vecs[2] = '{20'd7,   10'd0, 0,   0,   0};
        vecs[3] = '{20'd1,   10'd1, 100, 50,  100};
        vecs[4] = '{20'd30,  10'd1, 100, 60,  4};
        vecs[5] = '{20'd150, 10'd1, 100, 100, 2};
        vecs[6] = '{20'd3,   10'd2, 200, 101, 68};

        // reset state and first-edge readiness
        drive(1'b0, 20'd0, 10'd0, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        check("reset {rdy,drop,done,bz}", {req_ready, req_dropped, tone_done, buzzer_out}, 0);
        reset_n = 1'b1;
        #1 check("ready before first edge", req_ready, 0);
        @(posedge sys_clock);
        #1 check("ready after first edge", req_ready, 1);
        @(negedge sys_clock);

        // table-driven single tones from IDLE
        for (int v = 0; v < 7; v++) begin
            check($sformatf("v%0d ready_idle", v), req_ready, 1);
            drive(1'b1, vecs[v].hp, vecs[v].dur, 1'b0);
            @(negedge sys_clock);
            drive(1'b0, 20'd0, 10'd0, 1'b0);
            done_rel = -1; done_cnt = 0; high = 0; changes = 0; prev = 1'b0;
            for (int rr = 0; rr < 320; rr++) begin
                if (tone_done) begin
                    done_cnt++;
                    if (done_rel < 0) done_rel = rr;
                end
                if (buzzer_out) high++;
                if (buzzer_out != prev) changes++;
                prev = buzzer_out;
                @(negedge sys_clock);
            end
            check($sformatf("v%0d done_rel", v), done_rel, vecs[v].done_rel);
            check($sformatf("v%0d done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d high_cycles", v), high, vecs[v].high);
            check($sformatf("v%0d transitions", v), changes, vecs[v].changes);
            check($sformatf("v%0d final_bz", v), buzzer_out, 0);
        end

        // second request at PLAY cycle 50, third during the gap
        drive(1'b1, 20'd10, 10'd3, 1'b0);
        @(negedge sys_clock);
        for (int rr = 0; rr < 700; rr++) begin
            rec_bz[rr] = buzzer_out; rec_td[rr] = tone_done;
            rec_rdy[rr] = req_ready; rec_drop[rr] = req_dropped;
            if (rr == 50) drive(1'b1, 20'd5, 10'd1, 1'b0);
`ifdef BEEP_QUEUE_EN
            else if (rr == 400) drive(1'b1, 20'd7, 10'd1, 1'b0);
`endif
            else drive(1'b0, 20'd0, 10'd0, 1'b0);
            @(negedge sys_clock);
        end
        check("q first done at 300", rec_td[300], 1);
`ifdef BEEP_QUEUE_EN
        check("q ready at 50", rec_rdy[50], 1);
        check("q no drop at 51", rec_drop[51], 0);
        check("q ready full at 51", rec_rdy[51], 0);
        check("q gap silent", count_ones(0, 300, 499), 0);
        check("q gap ready", rec_rdy[450], 0);
        check("q third dropped", rec_drop[401], 1);
        check("q second starts at 500", rec_bz[500], 1);
        check("q second toggles at 505", rec_bz[505], 0);
        check("q ready at 500", rec_rdy[500], 1);
        check("q second done at 600", rec_td[600], 1);
        check("q done count", count_ones(1, 0, 699), 2);
        check("q silent after", count_ones(0, 600, 699), 0);
`else
        check("nq ready at 50", rec_rdy[50], 0);
        check("nq drop at 51", rec_drop[51], 1);
        check("nq done count", count_ones(1, 0, 699), 1);
        check("nq silent after", count_ones(0, 300, 699), 0);
        check("nq idle after tone", rec_rdy[300], 1);
`endif

        // stop_req with tone_req at PLAY cycle 120
        drive(1'b1, 20'd10, 10'd3, 1'b0);
        @(negedge sys_clock);
        for (int rr = 0; rr < 401; rr++) begin
            rec_bz[rr] = buzzer_out; rec_td[rr] = tone_done;
            rec_rdy[rr] = req_ready; rec_drop[rr] = req_dropped;
            if (rr == 120) drive(1'b1, 20'd4, 10'd1, 1'b1);
            else drive(1'b0, 20'd0, 10'd0, 1'b0);
            @(negedge sys_clock);
        end
        check("stop bz at 120", rec_bz[120], 1);
        check("stop bz at 121", rec_bz[121], 0);
        check("stop idle at 121", rec_rdy[121], 1);
        check("stop drop at 121", rec_drop[121], 1);
        check("stop no done", count_ones(1, 0, 400), 0);
        check("stop silent", count_ones(0, 121, 400), 0);

        // asynchronous reset in the middle of a tone
        drive(1'b1, 20'd10, 10'd3, 1'b0);
        @(negedge sys_clock);
        drive(1'b0, 20'd0, 10'd0, 1'b0);
        repeat (3) @(negedge sys_clock);
        check("rst pre bz", buzzer_out, 1);
        #2 reset_n = 1'b0;
        #1 check("rst async bz", buzzer_out, 0);
        check("rst async ready", req_ready, 0);
        repeat (2) @(negedge sys_clock);
        check("rst held outputs", {req_ready, req_dropped, tone_done, buzzer_out}, 0);
        reset_n = 1'b1;
        #1 check("rst release ready pre-edge", req_ready, 0);
        @(posedge sys_clock);
        #1 check("rst release ready first edge", req_ready, 1);
        @(negedge sys_clock);
        check("rst no resume {done,bz}", {tone_done, buzzer_out}, 0);

        // randomized stimulus against the window model
        do_reset();
        tones.delete();
        exp_drop = 1'b0;
        for (int n = 0; n < 12000; n++) begin
            for (int i = tones.size() - 1; i >= 0; i--)
                if (tones[i].en < n) tones.delete(i);
            check($sformatf("rand n=%0d {rdy,drop,done,bz}", n),
                  {req_ready, req_dropped, tone_done, buzzer_out},
                  {m_ready(n), exp_drop, m_done(n), m_buzz(n)});
            if (n_total - n_pass > 20) break;
            r = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 399) == 0);
            case ($urandom_range(0, 7))
                0:       h = 20'd0;
                1:       h = 20'($urandom);
                default: h = 20'($urandom_range(1, 25));
            endcase
            d = 10'($urandom_range(0, 2));
            rdy = m_ready(n);
            exp_drop = r && (!rdy || s);
            if (s) begin
                for (int i = tones.size() - 1; i >= 0; i--)
                    if (tones[i].en > n) tones.delete(i);
            end else if (r && rdy) begin
                if (m_idle(n)) begin
                    tones.push_back('{n + 1, n + 1 + int'(d) * CPM, int'(h)});
                end else begin
                    last = 0;
                    foreach (tones[i]) if (tones[i].en > last) last = tones[i].en;
                    st = last + GAP_CYC;
                    tones.push_back('{st, st + int'(d) * CPM, int'(h)});
                end
            end
            drive(r, h, d, s);
            @(negedge sys_clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
